// File: rtl/tag_ram_ctrl_pkg.sv
// Shared types and helpers for the tag RAM port-0 controller.
package tag_ram_ctrl_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int STAT_WIDTH = 32;

  function automatic int ram_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, scan starts one above the last granted index.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_reg;
  logic [PTR_W-1:0] ptr_next;
  logic             found;
  int               idx;

  always_comb begin
    gnt      = '0;
    ptr_next = ptr_reg;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(ptr_reg) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_next = PTR_W'(idx);
      end
    end
  end

  // Pointer only moves on a real grant so an idle cycle keeps fairness intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= PTR_W'(NUM_REQ - 1);
    end else if (advance && found) begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/tag_ram_ctrl.sv
// Port-0 front end of the FIX parser tag RAM: clear sweep, round-robin client access, fixed-latency reads.
// Optional statistics counters are enabled with TAG_RAM_CTRL_STATS_EN.
module tag_ram_ctrl
  import tag_ram_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    NUM_REQ    = 4,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             clear,
  output logic                             init_done,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic [ADDR_WIDTH-1:0]            ram_addr,
  output logic [DATA_WIDTH-1:0]            ram_wdata,
  output logic                             ram_cs,
  output logic                             ram_we,
  output logic                             ram_oe,
  input  logic [DATA_WIDTH-1:0]            ram_rdata
`ifdef TAG_RAM_CTRL_STATS_EN
  , output logic [STAT_WIDTH-1:0]          stat_grants
  , output logic [STAT_WIDTH-1:0]          stat_stalls
`endif
);

  localparam int CW        = ADDR_WIDTH + 1;
  localparam int RAM_DEPTH = ram_depth(ADDR_WIDTH);

  state_e                  state_reg, state_next;
  logic [CW-1:0]           sweep_cnt_reg, sweep_cnt_next;
  logic [ADDR_WIDTH-1:0]   ram_addr_reg, ram_addr_next;
  logic [DATA_WIDTH-1:0]   ram_wdata_reg, ram_wdata_next;
  logic                    ram_cs_reg, ram_cs_next;
  logic                    ram_we_reg, ram_we_next;
  logic                    ram_oe_reg, ram_oe_next;
  logic [NUM_REQ-1:0]      rd_pend_reg, rd_pend_next;
  logic [NUM_REQ-1:0]      rsp_valid_reg;

  logic                    run;
  logic [NUM_REQ-1:0]      arb_req;
  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    sel_we;

  assign run     = (state_reg == RUN);
  assign arb_req = run ? req : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (arb_req),
    .advance (run),
    .gnt     (gnt)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_we    = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr  = addr_arr[i];
        sel_wdata = wdata_arr[i];
        sel_we    = req_we[i];
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    sweep_cnt_next = sweep_cnt_reg;
    ram_addr_next  = ram_addr_reg;
    ram_wdata_next = ram_wdata_reg;
    ram_cs_next    = 1'b0;
    ram_we_next    = 1'b0;
    ram_oe_next    = 1'b0;
    rd_pend_next   = '0;
    case (state_reg)
      INIT: begin
        // The counter runs one past the last address so RUN starts after the final write is on the pins.
        if (sweep_cnt_reg != CW'(RAM_DEPTH)) begin
          ram_cs_next    = 1'b1;
          ram_we_next    = 1'b1;
          ram_addr_next  = sweep_cnt_reg[ADDR_WIDTH-1:0];
          ram_wdata_next = INIT_VALUE;
          sweep_cnt_next = sweep_cnt_reg + CW'(1);
        end else begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (|gnt) begin
          ram_cs_next    = 1'b1;
          ram_we_next    = sel_we;
          ram_oe_next    = ~sel_we;
          ram_addr_next  = sel_addr;
          ram_wdata_next = sel_wdata;
          rd_pend_next   = sel_we ? '0 : gnt;
        end
      end
      default: state_next = INIT;
    endcase
    if (clear) begin
      state_next     = INIT;
      sweep_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= INIT;
      sweep_cnt_reg <= '0;
      ram_addr_reg  <= '0;
      ram_wdata_reg <= '0;
      ram_cs_reg    <= 1'b0;
      ram_we_reg    <= 1'b0;
      ram_oe_reg    <= 1'b0;
      rd_pend_reg   <= '0;
      rsp_valid_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sweep_cnt_reg <= sweep_cnt_next;
      ram_addr_reg  <= ram_addr_next;
      ram_wdata_reg <= ram_wdata_next;
      ram_cs_reg    <= ram_cs_next;
      ram_we_reg    <= ram_we_next;
      ram_oe_reg    <= ram_oe_next;
      rd_pend_reg   <= rd_pend_next;
      rsp_valid_reg <= rd_pend_reg;
    end
  end

  assign init_done = run;
  assign ram_addr  = ram_addr_reg;
  assign ram_wdata = ram_wdata_reg;
  assign ram_cs    = ram_cs_reg;
  assign ram_we    = ram_we_reg;
  assign ram_oe    = ram_oe_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = (|rsp_valid_reg) ? ram_rdata : '0;

`ifdef TAG_RAM_CTRL_STATS_EN
  logic [STAT_WIDTH-1:0] stat_grants_reg;
  logic [STAT_WIDTH-1:0] stat_stalls_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_grants_reg <= '0;
      stat_stalls_reg <= '0;
    end else if (clear) begin
      stat_grants_reg <= '0;
      stat_stalls_reg <= '0;
    end else if (run) begin
      if ((|gnt) && !(&stat_grants_reg)) begin
        stat_grants_reg <= stat_grants_reg + STAT_WIDTH'(1);
      end
      if ((|(req & ~gnt)) && !(&stat_stalls_reg)) begin
        stat_stalls_reg <= stat_stalls_reg + STAT_WIDTH'(1);
      end
    end
  end

  assign stat_grants = stat_grants_reg;
  assign stat_stalls = stat_stalls_reg;
`endif

endmodule

// File: tb/tb_tag_ram_ctrl.sv
// Scoreboard bench for tag_ram_ctrl with a registered-read RAM model on port 0.
module tb_tag_ram_ctrl;

  localparam int             AW     = 4;
  localparam int             DW     = 32;
  localparam int             NR     = 4;
  localparam logic [DW-1:0]  INIT_V = 32'h0;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            clear;
  logic            init_done;
  logic [NR-1:0]   req, req_we, gnt, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_data, ram_wdata, ram_rdata;
  logic [AW-1:0]   ram_addr;
  logic            ram_cs, ram_we, ram_oe;
`ifdef TAG_RAM_CTRL_STATS_EN
  logic [31:0]     stat_grants, stat_stalls;
`endif

  tag_ram_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .INIT_VALUE (INIT_V)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .init_done (init_done),
    .req       (req),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_cs    (ram_cs),
    .ram_we    (ram_we),
    .ram_oe    (ram_oe),
    .ram_rdata (ram_rdata)
`ifdef TAG_RAM_CTRL_STATS_EN
    , .stat_grants (stat_grants)
    , .stat_stalls (stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  int cycle_cnt = 0;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // RAM model; prefill puts non-init garbage in every word so the sweep is observable.
  logic          prefill;
  logic [DW-1:0] ram_mem [16];
  always @(posedge clk) begin
    if (prefill) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= 32'hBAD0_0000 | i;
    end else if (ram_cs) begin
      if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      if (ram_oe) ram_rdata <= ram_mem[ram_addr];
    end
  end

  typedef struct {
    int            client;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb_q [$];
  logic [DW-1:0] exp_mem [16];
  int            errors = 0;
  int            checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("check %s ok: %0h", name, act);
    end
  endtask

  // Monitor: every response must match the oldest expected read, including its cycle.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if (rsp_valid != '0) begin
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: rsp_valid=%b data=%h, none expected", rsp_valid, rsp_data);
      end else begin
        e = sb_q.pop_front();
        if (rsp_valid !== (4'b0001 << e.client) || rsp_data !== e.data || cycle_cnt != e.due) begin
          errors++;
          $display("FAIL rsp: got valid=%b data=%h cycle=%0d expected client=%0d data=%h cycle=%0d",
                   rsp_valid, rsp_data, cycle_cnt, e.client, e.data, e.due);
        end else begin
          $display("rsp client %0d data %h ok", e.client, rsp_data);
        end
      end
    end else if (rsp_data !== '0) begin
      errors++;
      $display("FAIL rsp_idle: rsp_data=%h expected 0", rsp_data);
    end
  end

  task automatic mem_reset();
    for (int i = 0; i < 16; i++) exp_mem[i] = INIT_V;
  endtask

  task automatic issue(input int c, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_we[c]              = we;
    req_addr[c*AW +: AW]   = a;
    req_wdata[c*DW +: DW]  = d;
    req[c]                 = 1'b1;
  endtask

  // One cycle: sample grant at negedge, log the transaction, drop granted requests after the edge.
  task automatic step(input logic [NR-1:0] exp_g, input bit chk_g, input bit keep);
    logic [NR-1:0] g;
    exp_t          e;
    @(negedge clk);
    g = gnt;
    if (chk_g) check("gnt", 128'(g), 128'(exp_g));
    for (int i = 0; i < NR; i++) begin
      if (g[i]) begin
        if (req_we[i]) begin
          exp_mem[req_addr[i*AW +: AW]] = req_wdata[i*DW +: DW];
          $display("grant client %0d write addr %h data %h", i, req_addr[i*AW +: AW], req_wdata[i*DW +: DW]);
        end else begin
          e.client = i;
          e.data   = exp_mem[req_addr[i*AW +: AW]];
          e.due    = cycle_cnt + 2;
          sb_q.push_back(e);
          $display("grant client %0d read addr %h", i, req_addr[i*AW +: AW]);
        end
      end
    end
    @(posedge clk);
    #1;
    if (!keep) req = req & ~g;
  endtask

  task automatic sweep_check(input int k);
    check($sformatf("sweep%0d", k),
          128'({ram_cs, ram_we, ram_oe, ram_addr, ram_wdata, init_done, gnt}),
          128'({1'b1, 1'b1, 1'b0, 4'(k), INIT_V, 1'b0, 4'b0000}));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; clear = 1'b0; prefill = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    mem_reset();
    repeat (2) @(posedge clk);
    #1 prefill = 1'b0;
    @(negedge clk);
    check("reset_outputs",
          128'({gnt, rsp_valid, rsp_data, init_done, ram_addr, ram_wdata, ram_cs, ram_we, ram_oe}), 128'(0));

    // Sweep after reset: 16 writes, init_done in cycle 17.
    rst_n = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      sweep_check(k - 1);
    end
    @(negedge clk);
    check("init_done_c17", 128'({init_done, ram_cs}), 128'({1'b1, 1'b0}));
    @(posedge clk); #1;
    issue(0, 1'b0, 4'h7, '0);
    step(4'b0001, 1, 0);

    // Write by client 1 then read of the same address by client 2 in the next cycle.
    issue(1, 1'b1, 4'hC, 32'hDEADBEEF);
    step(4'b0010, 1, 0);
    issue(2, 1'b0, 4'hC, '0);
    step(4'b0100, 1, 0);
    repeat (2) step('0, 0, 0);

    // All four clients continuously: rotation 3,0,1,2,... and ram_cs never drops.
    issue(0, 1'b1, 4'h5, 32'h0000_0055);
    issue(1, 1'b0, 4'h5, '0);
    issue(2, 1'b0, 4'hA, '0);
    issue(3, 1'b0, 4'hC, '0);
    for (int k = 0; k < 8; k++) begin
      step(4'b1000 >> ((3 - ((k + 3) % 4))), 1, 1);
      if (k > 0) check("cs_busy", 128'(ram_cs), 128'(1));
    end
    req = '0;

    // Clear one cycle after a read grant: the read still completes, then a full sweep with no grants.
    issue(1, 1'b0, 4'hC, '0);
    step(4'b0010, 1, 0);
    clear = 1'b1;
    mem_reset();
    @(negedge clk);
    check("clear_cycle", 128'({init_done, gnt}), 128'({1'b1, 4'b0000}));
    @(posedge clk); #1;
    clear = 1'b0;
    issue(3, 1'b0, 4'h0, '0);
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      if (k == 0) check("clear_idle", 128'({init_done, gnt, ram_cs}), 128'(0));
      else sweep_check(k - 1);
    end
    step(4'b1000, 1, 0);
    repeat (3) step('0, 0, 0);

`ifdef TAG_RAM_CTRL_STATS_EN
    clear = 1'b1;
    mem_reset();
    @(posedge clk); #1;
    clear = 1'b0;
    n = 0;
    while (n < 40 && !init_done) begin
      @(negedge clk);
      n++;
    end
    check("stats_init", 128'(init_done), 128'(1));
    @(posedge clk); #1;
    issue(0, 1'b0, 4'h1, '0);
    issue(1, 1'b0, 4'h2, '0);
    issue(2, 1'b0, 4'h3, '0);
    for (int k = 0; k < 10; k++) step('0, 0, 1);
    req = '0;
    check("stat_grants", 128'(stat_grants), 128'(10));
    check("stat_stalls", 128'(stat_stalls), 128'(10));
    repeat (3) step('0, 0, 0);
`endif

    // Reset one cycle after a read grant: response is dropped and outputs clear immediately.
    issue(2, 1'b0, 4'h0, '0);
    step('0, 0, 0);
    rst_n = 1'b0;
    sb_q.delete();
    mem_reset();
    #1;
    check("async_reset",
          128'({gnt, rsp_valid, rsp_data, init_done, ram_addr, ram_wdata, ram_cs, ram_we, ram_oe}), 128'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (n < 40 && !init_done) begin
      @(negedge clk);
      n++;
    end
    check("resweep_len", 128'(n), 128'(17));
    @(posedge clk); #1;
    issue(0, 1'b0, 4'hC, '0);
    step(4'b0001, 1, 0);
    repeat (4) step('0, 0, 0);
    check("sb_empty", 128'(sb_q.size()), 128'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
